// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and access sequencer in front of a single-port,
// byte-addressed, little-endian data memory. Port 0 is the CPU MEM stage and
// port 1 is a secondary master such as a debug loader or DMA engine.
//
// One access is granted at a time, with round-robin fairness. The memory
// interface is held stable for LATENCY cycles per access. The granted port
// then gets a one-cycle ack, and its read data is registered.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous, active-low reset
//   reqN_i       port N request; held until ackN_o
//   weN_i        port N write enable (1 = store, 0 = load)
//   addrN_i      port N byte address
//   wdataN_i     port N store data
//   ackN_o       port N completion pulse (one cycle)
//   rdataN_o     port N load data; holds until that port's next load completes
//   mem_read_o   memory read strobe (every ACCESS cycle of a load)
//   mem_write_o  memory write strobe (first ACCESS cycle of a store only)
//   mem_addr_o   memory address, driven from the latched request
//   mem_wdata_o  memory write data, driven from the latched request
//   mem_rdata_i  memory combinational read data
//   busy_o       high while an access is in flight (ACCESS or DONE)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2     // legal range 1..15
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,

  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,

  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // The counter is loaded with LATENCY-1, so the ACCESS phase lasts LATENCY cycles.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]        state_q,      state_d;
  logic [3:0]        cnt_q,        cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q,        gnt_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [DATA_W-1:0] rdata0_q,     rdata0_d;
  logic [DATA_W-1:0] rdata1_q,     rdata1_d;

  // Port 1 wins when it is the only requester. It also wins when both ports
  // request and port 0 took the previous grant.
  logic sel1;
  assign sel1 = req1_i & (~req0_i | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          // Latch the whole request. Requester inputs are ignored from here on.
          gnt_d        = sel1;
          last_grant_d = sel1;
          we_d         = sel1 ? we1_i    : we0_i;
          addr_d       = sel1 ? addr1_i  : addr0_i;
          wdata_d      = sel1 ? wdata1_i : wdata0_i;
          cnt_d        = CNT_INIT;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last ACCESS cycle: capture load data for the granted port.
          state_d = S_DONE;
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_rdata_i;
            else       rdata0_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // The address and data come straight from the latch registers, so they hold
  // through DONE and IDLE. The strobes qualify them.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_read_o  = (state_q == S_ACCESS) & ~we_q;
  // Only the first ACCESS cycle writes, so a store gives exactly one write edge.
  assign mem_write_o = (state_q == S_ACCESS) & we_q & (cnt_q == CNT_INIT);

  assign ack0_o   = (state_q == S_DONE) & ~gnt_q;
  assign ack1_o   = (state_q == S_DONE) &  gnt_q;
  assign busy_o   = (state_q == S_ACCESS) | (state_q == S_DONE);
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. It instantiates two copies of the design:
//   u_dut  - LATENCY=2
//   u_dut1 - LATENCY=1
// Each copy has its own little-endian byte-array memory model.
//
// Time is counted in cycles after the cycle in which a request is presented
// (cycle 0). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;

  // LATENCY=2 instance signals
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, mem_rd, mem_wr, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  // LATENCY=1 instance signals
  logic        b_req0, b_we0, b_req1, b_we1;
  logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1;
  logic        b_ack0, b_ack1, b_mem_rd, b_mem_wr, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [7:0]  mem0 [0:255];
  logic [7:0]  mem1 [0:255];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .rdata1_o(rdata1),
    .mem_read_o(mem_rd), .mem_write_o(mem_wr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0),
    .ack0_o(b_ack0), .rdata0_o(b_rdata0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1),
    .ack1_o(b_ack1), .rdata1_o(b_rdata1),
    .mem_read_o(b_mem_rd), .mem_write_o(b_mem_wr), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory models. Reads are combinational; writes land on the
  // rising edge when the write strobe is high.
  function automatic logic [31:0] rd0(input logic [7:0] a);
    return {mem0[8'(a + 8'd3)], mem0[8'(a + 8'd2)], mem0[8'(a + 8'd1)], mem0[a]};
  endfunction
  function automatic logic [31:0] rd1(input logic [7:0] a);
    return {mem1[8'(a + 8'd3)], mem1[8'(a + 8'd2)], mem1[8'(a + 8'd1)], mem1[a]};
  endfunction

  assign mem_rdata   = rd0(mem_addr[7:0]);
  assign b_mem_rdata = rd1(b_mem_addr[7:0]);

  always @(posedge clk) begin
    if (mem_wr) begin
      mem0[mem_addr[7:0]]           <= mem_wdata[7:0];
      mem0[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
      mem0[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
      mem0[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
    end
    if (b_mem_wr) begin
      mem1[b_mem_addr[7:0]]           <= b_mem_wdata[7:0];
      mem1[8'(b_mem_addr[7:0] + 8'd1)] <= b_mem_wdata[15:8];
      mem1[8'(b_mem_addr[7:0] + 8'd2)] <= b_mem_wdata[23:16];
      mem1[8'(b_mem_addr[7:0] + 8'd3)] <= b_mem_wdata[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs one access on the LATENCY=2 instance, starting in the current cycle
  // (cycle 0). It checks the ack cycle, the strobe counts, the latched
  // address/data in cycle 1, and that the other port never acks.
  task automatic do_access(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    int ack_cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int other_ack = 0;
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else        begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    for (int c = 1; c <= 40; c++) begin
      step();
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
      if (c == 1) begin
        chk({tag, "_addr"}, mem_addr, addr);
        if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
      end
      if ((p == 0 && ack1) || (p == 1 && ack0)) other_ack++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        ack_cyc = c;
        break;
      end
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'd3);
    chk({tag, "_reads"},     32'(n_rd),    we ? 32'd0 : 32'd2);
    chk({tag, "_writes"},    32'(n_wr),    we ? 32'd1 : 32'd0);
    chk({tag, "_other_ack"}, 32'(other_ack), 32'd0);
    step();
    chk({tag, "_ack_drop"}, {31'd0, (p == 0) ? ack0 : ack1}, 32'd0);
    chk({tag, "_idle"},     {31'd0, busy}, 32'd0);
  endtask

  int   a0c, a1c, ng;
  int   order [0:5];

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
    b_req1 = 0; b_we1 = 0; b_addr1 = 0; b_wdata1 = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] <= 8'h00;
      mem1[i] <= 8'h00;
    end
    #1;
    mem0[0] <= 8'h11; mem0[1] <= 8'h22; mem0[2] <= 8'h33; mem0[3] <= 8'h44;
    mem1[4] <= 8'h55; mem1[5] <= 8'h66; mem1[6] <= 8'h77; mem1[7] <= 8'h88;
    repeat (3) step();

    // Reset state
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_ack0",   {31'd0, ack0},   32'd0);
    chk("rst_ack1",   {31'd0, ack1},   32'd0);
    chk("rst_rd",     {31'd0, mem_rd}, 32'd0);
    chk("rst_wr",     {31'd0, mem_wr}, 32'd0);
    chk("rst_addr",   mem_addr,  32'd0);
    chk("rst_wdata",  mem_wdata, 32'd0);
    chk("rst_rdata0", rdata0,    32'd0);
    chk("rst_rdata1", rdata1,    32'd0);
    rst_n = 1'b1;

    // Port 0 load from address 0
    do_access(0, 1'b0, 32'd0, 32'd0, "t1_p0_load");
    chk("t1_rdata0", rdata0, 32'h44332211);

    // Port 1 store, then port 1 load of the same word
    do_access(1, 1'b1, 32'd8, 32'hDEADBEEF, "t2_p1_store");
    chk("t2_mem8", rd0(8'd8), 32'hDEADBEEF);
    chk("t2_rdata1_after_store", rdata1, 32'd0);
    do_access(1, 1'b0, 32'd8, 32'd0, "t2_p1_load");
    chk("t2_rdata1", rdata1, 32'hDEADBEEF);
    chk("t2_rdata0_kept", rdata0, 32'h44332211);

    // Both ports request in cycle 0 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1; we0 = 0; addr0 = 32'd0;
    req1 = 1; we1 = 0; addr1 = 32'd8;
    a0c = 0; a1c = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ack0 && a0c == 0) begin a0c = c; req0 = 0; end
      if (ack1 && a1c == 0) begin a1c = c; req1 = 0; end
      if (a0c != 0 && a1c != 0) break;
    end
    req0 = 0; req1 = 0;
    chk("t3_ack0_cycle", 32'(a0c), 32'd3);
    chk("t3_ack1_cycle", 32'(a1c), 32'd7);
    chk("t3_rdata0", rdata0, 32'h44332211);
    chk("t3_rdata1", rdata1, 32'hDEADBEEF);
    step();

    // Both ports request continuously: grants must alternate
    for (int i = 0; i < 6; i++) order[i] = 9;
    ng = 0;
    req0 = 1; req1 = 1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (ack0) begin order[ng] = 0; ng++; end
      else if (ack1) begin order[ng] = 1; ng++; end
      if (ng == 6) break;
    end
    req0 = 0; req1 = 0;
    chk("t4_grant_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(i % 2));
    step();

    // Reset in the second ACCESS cycle of a port 0 store
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1; we0 = 1; addr0 = 32'd16; wdata0 = 32'hCAFEF00D;
    step();
    chk("t5_wr_c1", {31'd0, mem_wr}, 32'd1);
    step();
    chk("t5_busy_c2", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    req0 = 0; we0 = 0;
    chk("t5_busy",   {31'd0, busy},   32'd0);
    chk("t5_wr",     {31'd0, mem_wr}, 32'd0);
    chk("t5_rd",     {31'd0, mem_rd}, 32'd0);
    chk("t5_ack0",   {31'd0, ack0},   32'd0);
    chk("t5_addr",   mem_addr,  32'd0);
    chk("t5_wdata",  mem_wdata, 32'd0);
    chk("t5_rdata0", rdata0,    32'd0);
    chk("t5_mem16",  rd0(8'd16), 32'hCAFEF00D);
    step();
    rst_n = 1'b1;
    do_access(1, 1'b0, 32'd16, 32'd0, "t5_p1_load");
    chk("t5_rdata1", rdata1, 32'hCAFEF00D);

    // LATENCY=1 instance: load, then store
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'd4;
    step();
    chk("t6_load_rd_c1", {31'd0, b_mem_rd}, 32'd1);
    chk("t6_load_ack_c1", {31'd0, b_ack0}, 32'd0);
    step();
    chk("t6_load_ack_c2", {31'd0, b_ack0}, 32'd1);
    chk("t6_load_rd_c2", {31'd0, b_mem_rd}, 32'd0);
    chk("t6_rdata0", b_rdata0, 32'h88776655);
    b_req0 = 0;
    step();
    chk("t6_load_ack_c3", {31'd0, b_ack0}, 32'd0);
    b_req0 = 1; b_we0 = 1; b_addr0 = 32'd12; b_wdata0 = 32'h0BADF00D;
    step();
    chk("t6_store_wr_c1", {31'd0, b_mem_wr}, 32'd1);
    chk("t6_store_rd_c1", {31'd0, b_mem_rd}, 32'd0);
    step();
    chk("t6_store_ack_c2", {31'd0, b_ack0}, 32'd1);
    chk("t6_store_wr_c2", {31'd0, b_mem_wr}, 32'd0);
    b_req0 = 0; b_we0 = 0;
    step();
    chk("t6_mem12", rd1(8'd12), 32'h0BADF00D);
    chk("t6_rdata0_kept", b_rdata0, 32'h88776655);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port, byte-addressed, little-endian 32-bit data memory.
- Port 0 is the CPU MEM stage; port 1 is a secondary master (debug loader or DMA).
- Grants one access at a time with round-robin fairness, holds the memory interface stable for a programmable latency, and returns a one-cycle ack with the read data registered.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width; the memory packs 4 bytes little-endian.
- LATENCY, 2, cycles the memory interface is held per access; legal range 1..15.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req0_i  in  1  port 0 request; held until ack0_o.
- we0_i  in  1  port 0 write enable (1 = store, 0 = load).
- addr0_i  in  ADDR_W  port 0 byte address.
- wdata0_i  in  DATA_W  port 0 store data.
- ack0_o  out  1  port 0 completion pulse.
- rdata0_o  out  DATA_W  port 0 load data, registered.
- req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o: same as port 0, for port 1.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory combinational read data.
- busy_o  out  1  high while an access is in flight.

Behaviour:
- Reset (rst_i low, async): state=IDLE, counter=0, last_grant=1 (port 0 wins first), all outputs 0, rdata0_o/rdata1_o=0.
- States:
  - IDLE -> ACCESS: when any req is high.
  - ACCESS -> DONE: when counter reaches 0.
  - DONE -> IDLE: unconditionally.
- Arbitration (IDLE only):
  - Single request: that port is granted.
  - Both requesting: the port != last_grant is granted.
  - last_grant updates on every grant.
- On grant, latch we, addr, wdata and grant id into internal registers; set counter=LATENCY-1. Requester inputs are ignored after the latch.
- ACCESS:
  - mem_addr_o and mem_wdata_o are driven from the latched registers.
  - Load: mem_read_o=1 for every ACCESS cycle.
  - Store: mem_write_o=1 on the first ACCESS cycle only, so exactly one memory write edge per store regardless of LATENCY.
  - Counter decrements each cycle.
  - On the last ACCESS cycle of a load, mem_rdata_i is captured into rdata of the granted port.
- DONE:
  - ack of the granted port =1 for exactly one cycle.
  - mem strobes=0; mem_addr_o/mem_wdata_o hold their last value.
- Outside ACCESS, mem_read_o and mem_write_o are 0.
- busy_o=1 in ACCESS and DONE.
- Latency: req sampled in IDLE at edge N, ACCESS for cycles N+1..N+LATENCY, ack in cycle N+LATENCY+1, minimum one IDLE cycle between accesses.
- Requester contract: deassert req or present a new request at the edge where ack is sampled; a req still high in the following IDLE cycle is a new request.
- rdata of a port holds until that port's next load completes; stores leave it unchanged.
- Addresses pass through unmodified; no alignment check, no bounds check.
- Req dropped mid-access: the access completes and ack still pulses.
- Reset mid-access: abort immediately to reset values; a store whose write edge already occurred stays in memory.
- LATENCY=1: a single ACCESS cycle that carries both the write strobe and the read capture.

Test Plan:
- Reset, mem[0..3]=0x11,0x22,0x33,0x44; port 0 load addr 0 at cycle 0, LATENCY=2 -> mem_read_o high cycles 1-2, ack0_o cycle 3 only, rdata0_o=0x44332211.
- Port 1 store addr 8 data 0xDEADBEEF -> mem_write_o high exactly one cycle; then port 1 load addr 8 -> rdata1_o=0xDEADBEEF; rdata0_o unchanged.
- Both request at cycle 0 after reset, held -> ack0_o cycle 3, port 1 granted cycle 4, ack1_o cycle 7.
- Both request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1; neither port gets two consecutive grants.
- Port 0 store, rst_i low during second ACCESS cycle -> all outputs 0 immediately; memory holds the stored word; a fresh port 1 load completes normally after release.
- LATENCY=1 build, port 0 load -> ack0_o at cycle 2 with correct data; a store gives one write strobe.
